forwarding_scoreboard: RTL and testbench
========================================

Name: forwarding_scoreboard

Overview:
- Parametrised successor of the two-stage forwarding unit.
- Tracks in-flight register writes in a shift pipeline of NUM_STAGES post-EXE records and drives per-operand forwarding selects for the instruction in EXE.
- Detects load-use hazards: asserts stall and inserts a bubble when the youngest matching producer's data is not yet available.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- REG_ADDR_W, 4: register address width.
- NUM_SRC, 2: source operands checked per instruction.
- NUM_STAGES, 2: post-EXE stages tracked; stage 1 = MEM, stage NUM_STAGES = WB. Legal range 2..7.
- LOAD_READY_STAGE, 2: first stage index from which a load result may be forwarded.
- SEL_W, 3: select width; must satisfy 2^SEL_W > NUM_STAGES.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- forwarding_enable  in  1  1 = forward; 0 = stall-until-written mode.
- freeze  in  1  global pipeline hold (memory wait); tracker holds its state.
- flush  in  1  squash the instruction currently in EXE.
- issue_valid  in  1  the EXE instruction is valid.
- issue_wb_en  in  1  the EXE instruction writes a register.
- issue_dest  in  REG_ADDR_W  destination of the EXE instruction.
- issue_is_load  in  1  the EXE instruction is a memory load.
- src_addr  in  NUM_SRC*REG_ADDR_W  source register addresses; operand i at bits [i*REG_ADDR_W +: REG_ADDR_W].
- src_used  in  NUM_SRC  operand i actually reads a register.
- sel_op  out  NUM_SRC*SEL_W  per-operand select.
  - 0 = register-file/ID value.
  - k = value from stage k.
- stall  out  1  hold EXE and earlier stages; insert a bubble.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- State: NUM_STAGES records {valid, wb_en, dest, is_load}. A record matches operand i when all hold: valid, wb_en, src_used[i], dest == operand address.
- Reset (async): all records invalid; stall_cycles = 0. Consequently sel_op = 0 and stall = 0 during and after reset.
- sel_op and stall are combinational from records and inputs, with zero latency.
- Forwarding mode (forwarding_enable = 1), per operand:
  - Find the matching record with the smallest index k (youngest producer).
  - No match: sel = 0.
  - Matched record is a load with k < LOAD_READY_STAGE: sel = 0, and the operand requests a stall.
  - Otherwise: sel = k. Younger always wins, e.g. a MEM match beats a WB match.
- Stall-until-written mode (forwarding_enable = 0): all sel = 0; an operand requests a stall if any record matches.
- stall = OR of operand requests, gated by issue_valid & ~flush.
- Clock edge, in priority order:
  1. rst: clear all records and the counter.
  2. freeze = 1: hold all records and the counter. stall and sel still evaluate.
  3. Otherwise:
     - Record k <= record k-1 for k = 2..NUM_STAGES; the oldest record is discarded.
     - Record 1 <= bubble (valid = 0) if stall or flush; else {issue_valid, issue_wb_en, issue_dest, issue_is_load}.
     - If stall = 1, stall_cycles increments, saturating at all-ones with no wrap.
- Simultaneous flush and hazard: flush wins. stall = 0 and a bubble enters stage 1.
- Operand addresses equal to each other, or an instruction reading its own destination: no self-match, because the EXE instruction is not yet in the records.
- Reset asserted mid-stall: stall drops immediately (async); the counter clears.

Test Plan:
1. Back-to-back ALU dependency: ADD r3 in stage 1, next op src0 = r3 -> sel_op[0] = 1, stall = 0. One cycle later, src1 = r3 -> sel_op[1] = 2.
2. Double producer: r5 written in stage 1 and stage 2, src0 = r5 -> sel_op[0] = 1 (youngest wins).
3. Load-use: LDR r2 enters stage 1, next op src1 = r2 -> stall = 1 for exactly 1 cycle, bubble enters stage 1, stall_cycles = 1. Next cycle: sel_op[1] = 2, stall = 0.
4. Freeze during load-use: freeze = 1 for 3 cycles -> stall stays 1, records and counter unchanged. After release -> same sequence as scenario 3.
5. Stall-until-written mode: enable = 0, r4 in stage 1, src0 = r4 -> stall high for 2 cycles until r4 leaves stage NUM_STAGES; sel_op = 0 throughout.
6. Flush and saturation:
   - flush = 1 with a pending hazard -> stall = 0 and stage 1 invalid next cycle.
   - CNT_W = 4 with 20 stalled cycles -> stall_cycles = 15.
   - Assert rst -> stall_cycles = 0 immediately.

Source files
------------

// File: rtl/forwarding_scoreboard.sv
// ---------------------------------------------------------------------------
// forwarding_scoreboard
//
// Tracks register writes that have left EXE in a shift pipeline of
// NUM_STAGES records (stage 1 = MEM, stage NUM_STAGES = WB). For each
// source operand of the instruction in EXE it selects the youngest producer
// to forward from, or requests a stall when the youngest producer's data is
// not yet available. It also keeps a saturating count of stalled cycles.
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous active-high reset
//   forwarding_enable_i  1 = forward, 0 = stall until the producer retires
//   freeze_i             global hold: records and counter keep their value
//   flush_i              squash the instruction in EXE
//   issue_valid_i        EXE instruction is valid
//   issue_wb_en_i        EXE instruction writes a register
//   issue_dest_i         EXE destination register
//   issue_is_load_i      EXE instruction is a memory load
//   src_addr_i           operand i at [i*REG_ADDR_W +: REG_ADDR_W]
//   src_used_i           operand i actually reads a register
//   sel_op_o             per-operand select: 0 = register file, k = stage k
//   stall_o              hold EXE and earlier stages, insert a bubble
//   stall_cycles_o       saturating stalled-cycle count
// ---------------------------------------------------------------------------
module forwarding_scoreboard #(
    parameter int REG_ADDR_W       = 4,
    parameter int NUM_SRC          = 2,
    parameter int NUM_STAGES       = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = 3,
    parameter int CNT_W            = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          forwarding_enable_i,
    input  logic                          freeze_i,
    input  logic                          flush_i,
    input  logic                          issue_valid_i,
    input  logic                          issue_wb_en_i,
    input  logic [REG_ADDR_W-1:0]         issue_dest_i,
    input  logic                          issue_is_load_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_i,
    input  logic [NUM_SRC-1:0]            src_used_i,
    output logic [NUM_SRC*SEL_W-1:0]      sel_op_o,
    output logic                          stall_o,
    output logic [CNT_W-1:0]              stall_cycles_o
);

    // Post-EXE records, index 1 is the youngest.
    logic [NUM_STAGES:1]   valid_q, valid_d;
    logic [NUM_STAGES:1]   wb_en_q, wb_en_d;
    logic [NUM_STAGES:1]   is_load_q, is_load_d;
    logic [REG_ADDR_W-1:0] dest_q [1:NUM_STAGES];
    logic [REG_ADDR_W-1:0] dest_d [1:NUM_STAGES];
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [NUM_SRC-1:0]    hit;
    logic [NUM_SRC-1:0]    hit_load;
    logic [SEL_W-1:0]      hit_k [NUM_SRC];
    logic [NUM_SRC-1:0]    stall_req;

    // Scan oldest to youngest so the youngest matching producer is the one
    // left in hit_k / hit_load.
    always_comb begin
        hit      = '0;
        hit_load = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hit_k[i] = '0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_STAGES; k >= 1; k--) begin
                if (valid_q[k] && wb_en_q[k] && src_used_i[i] &&
                    (dest_q[k] == src_addr_i[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    hit[i]      = 1'b1;
                    hit_k[i]    = SEL_W'(k);
                    hit_load[i] = is_load_q[k];
                end
            end
        end
    end

    always_comb begin
        sel_op_o  = '0;
        stall_req = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (forwarding_enable_i) begin
                if (hit[i]) begin
                    // A load result only exists from LOAD_READY_STAGE onward.
                    if (hit_load[i] && (int'(hit_k[i]) < LOAD_READY_STAGE)) begin
                        stall_req[i] = 1'b1;
                    end else begin
                        sel_op_o[i*SEL_W +: SEL_W] = hit_k[i];
                    end
                end
            end else begin
                stall_req[i] = hit[i];
            end
        end
    end

    // Flush wins over a hazard: a squashed instruction never stalls.
    assign stall_o        = (|stall_req) & issue_valid_i & ~flush_i;
    assign stall_cycles_o = cnt_q;

    always_comb begin
        valid_d   = valid_q;
        wb_en_d   = wb_en_q;
        is_load_d = is_load_q;
        dest_d    = dest_q;
        cnt_d     = cnt_q;
        if (!freeze_i) begin
            for (int k = NUM_STAGES; k >= 2; k--) begin
                valid_d[k]   = valid_q[k-1];
                wb_en_d[k]   = wb_en_q[k-1];
                is_load_d[k] = is_load_q[k-1];
                dest_d[k]    = dest_q[k-1];
            end
            if (stall_o || flush_i) begin
                valid_d[1]   = 1'b0;
                wb_en_d[1]   = 1'b0;
                is_load_d[1] = 1'b0;
                dest_d[1]    = '0;
            end else begin
                valid_d[1]   = issue_valid_i;
                wb_en_d[1]   = issue_wb_en_i;
                is_load_d[1] = issue_is_load_i;
                dest_d[1]    = issue_dest_i;
            end
            if (stall_o && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            wb_en_q   <= '0;
            is_load_q <= '0;
            for (int k = 1; k <= NUM_STAGES; k++) begin
                dest_q[k] <= '0;
            end
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            wb_en_q   <= wb_en_d;
            is_load_q <= is_load_d;
            dest_q    <= dest_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
module tb_forwarding_scoreboard;

    localparam int REG_ADDR_W       = 4;
    localparam int NUM_SRC          = 2;
    localparam int NUM_STAGES       = 2;
    localparam int LOAD_READY_STAGE = 2;
    localparam int SEL_W            = 3;
    localparam int CNT_W            = 4;
    localparam int CNT_MAX          = (1 << CNT_W) - 1;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          fe, frz, fl, iv, wb, ld;
    logic [REG_ADDR_W-1:0]         dest;
    logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]            src_used;
    logic [NUM_SRC*SEL_W-1:0]      sel_op;
    logic                          stall;
    logic [CNT_W-1:0]              stall_cycles;

    always #5 clk = ~clk;

    forwarding_scoreboard #(
        .REG_ADDR_W(REG_ADDR_W), .NUM_SRC(NUM_SRC), .NUM_STAGES(NUM_STAGES),
        .LOAD_READY_STAGE(LOAD_READY_STAGE), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .forwarding_enable_i(fe), .freeze_i(frz), .flush_i(fl),
        .issue_valid_i(iv), .issue_wb_en_i(wb), .issue_dest_i(dest),
        .issue_is_load_i(ld), .src_addr_i(src_addr), .src_used_i(src_used),
        .sel_op_o(sel_op), .stall_o(stall), .stall_cycles_o(stall_cycles)
    );

    // Reference model: a list of in-flight writes, element 0 = MEM stage.
    typedef struct {
        bit       v;
        bit       w;
        bit [3:0] d;
        bit       l;
    } rec_t;

    typedef struct {
        logic [NUM_SRC*SEL_W-1:0] sel;
        logic                     stl;
        logic [CNT_W-1:0]         cnt;
    } exp_t;

    rec_t hist[$];
    int   mcnt;
    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void model_clear();
        rec_t z;
        z = '{v: 1'b0, w: 1'b0, d: 4'd0, l: 1'b0};
        hist.delete();
        for (int k = 0; k < NUM_STAGES; k++) hist.push_back(z);
        mcnt = 0;
    endfunction

    function automatic void model_eval(output logic [NUM_SRC*SEL_W-1:0] sel, output logic stl);
        bit req;
        req = 1'b0;
        sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            int       youngest;
            bit [3:0] a;
            youngest = 0;
            a = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
            if (src_used[i]) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    if (hist[k].v && hist[k].w && hist[k].d == a) begin
                        youngest = k + 1;
                        break;
                    end
                end
            end
            if (youngest != 0) begin
                if (!fe) req = 1'b1;
                else if (hist[youngest-1].l && youngest < LOAD_READY_STAGE) req = 1'b1;
                else sel[i*SEL_W +: SEL_W] = SEL_W'(youngest);
            end
        end
        stl = req && iv && !fl;
    endfunction

    function automatic void model_step(input logic stl);
        rec_t r;
        if (frz) return;
        if (stl || fl) r = '{v: 1'b0, w: 1'b0, d: 4'd0, l: 1'b0};
        else           r = '{v: iv, w: wb, d: dest, l: ld};
        hist.push_front(r);
        void'(hist.pop_back());
        if (stl && mcnt < CNT_MAX) mcnt++;
    endfunction

    // One issue cycle: drive inputs just after the edge, predict outputs,
    // then advance the model for the coming edge.
    task automatic cyc(input int r, input int f_e, input int fz, input int fls,
                       input int v, input int w, input int dd, input int l,
                       input int a0, input int a1, input int u);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = (r != 0);
        fe       = (f_e != 0);
        frz      = (fz != 0);
        fl       = (fls != 0);
        iv       = (v != 0);
        wb       = (w != 0);
        dest     = REG_ADDR_W'(dd);
        ld       = (l != 0);
        src_addr = {REG_ADDR_W'(a1), REG_ADDR_W'(a0)};
        src_used = NUM_SRC'(u);
        if (rst) model_clear();
        model_eval(e.sel, e.stl);
        e.cnt = CNT_W'(mcnt);
        expq.push_back(e);
        if (!rst) model_step(e.stl);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (sel_op !== e.sel) begin
                errors++;
                $display("FAIL sel_op t=%0t got %h expected %h", $time, sel_op, e.sel);
            end
            checks++;
            if (stall !== e.stl) begin
                errors++;
                $display("FAIL stall t=%0t got %b expected %b", $time, stall, e.stl);
            end
            checks++;
            if (stall_cycles !== e.cnt) begin
                errors++;
                $display("FAIL stall_cycles t=%0t got %0d expected %0d", $time, stall_cycles, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fe = 1'b1; frz = 1'b0; fl = 1'b0; iv = 1'b0; wb = 1'b0;
        ld = 1'b0; dest = '0; src_addr = '0; src_used = '0;
        model_clear();

        //  r fe fz fl  v  w  d  l a0 a1  u
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 1, 3, 0, 3, 3, 3);
        // back-to-back ALU dependency
        cyc(0, 1, 0, 0, 1, 1, 3, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 7, 0, 3, 0, 1);
        cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 3, 2);
        // double producer, youngest wins
        cyc(0, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 0, 0, 5, 5, 3);
        // load-use
        cyc(0, 1, 0, 0, 1, 1, 2, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 6, 0, 9, 2, 2);
        cyc(0, 1, 0, 0, 1, 1, 6, 0, 9, 2, 2);
        // freeze during load-use
        cyc(0, 1, 0, 0, 1, 1, 2, 1, 0, 0, 0);
        for (int n = 0; n < 3; n++) cyc(0, 1, 1, 0, 1, 1, 6, 0, 2, 2, 3);
        cyc(0, 1, 0, 0, 1, 1, 6, 0, 2, 2, 3);
        cyc(0, 1, 0, 0, 1, 1, 6, 0, 2, 2, 3);
        // stall-until-written mode
        cyc(0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0);
        for (int n = 0; n < 3; n++) cyc(0, 0, 0, 0, 1, 0, 0, 0, 4, 1, 1);
        // flush beats a pending hazard
        cyc(0, 1, 0, 0, 1, 1, 2, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 1, 1, 8, 0, 2, 0, 1);
        cyc(0, 1, 0, 0, 1, 0, 0, 0, 2, 0, 1);
        // saturate the counter
        for (int n = 0; n < 10; n++) begin
            cyc(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
            for (int m = 0; m < 3; m++) cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 3);
        end
        // reset in the middle of a stall
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // randomized traffic over a small register space to force collisions
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 99) == 0) ? 1 : 0,
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                ($urandom_range(0, 7) == 0) ? 1 : 0,
                ($urandom_range(0, 7) == 0) ? 1 : 0,
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        @(posedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
